// File: rtl/xfer_pkg.sv
// Shared types and defaults for the register-to-register transfer arbiter.
package xfer_pkg;

   // Transfer sequencer states
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DRIVE = 2'd1,
      LOAD  = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam int NREQ_DEF = 4;
   localparam int NREG_DEF = 8;

   // Index width that stays at least one bit wide for single-entry vectors
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after ptr,
// wrapping around modulo NREQ.
module rr_arbiter
   import xfer_pkg::*;
#(
   parameter  int NREQ = NREQ_DEF,
   localparam int GW   = idx_w(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [GW-1:0]   ptr,
   output logic [GW-1:0]   grant,
   output logic            valid
);

   // Scan NREQ positions starting at ptr; the first hit wins
   always_comb begin
      int idx;
      grant = '0;
      valid = 1'b0;
      idx   = 0;
      for (int i = 0; i < NREQ; i++) begin
         idx = int'(ptr) + i;
         if (idx >= NREQ) idx = idx - NREQ;
         if (!valid && req[idx]) begin
            valid = 1'b1;
            grant = GW'(idx);
         end
      end
   end

endmodule

// File: rtl/xfer_arbiter.sv
// Arbitrates register-to-register transfers over a shared internal bus.
// Each granted transfer runs DRIVE (bus settle), LOAD (destination capture)
// and DONE (ack). Outputs decode only registered state and latched indices,
// so they drop asynchronously with reset and never follow req/src/dst.
module xfer_arbiter
   import xfer_pkg::*;
#(
   parameter  int NREQ = NREQ_DEF,
   parameter  int NREG = NREG_DEF,
   localparam int IW   = idx_w(NREG),
   localparam int GW   = idx_w(NREQ)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NREQ-1:0]          req,
   input  logic [NREQ-1:0][IW-1:0]  src,
   input  logic [NREQ-1:0][IW-1:0]  dst,
   output logic [NREQ-1:0]          ack,
   output logic [NREG-1:0]          reg_oe,
   output logic [NREG-1:0]          reg_ce,
   output logic                     busy,
   output logic [GW-1:0]            grant_id
);

   state_t          state, state_nxt;
   logic [GW-1:0]   rr_ptr;
   logic [GW-1:0]   grant_q;
   logic [IW-1:0]   src_q, dst_q;
   logic [GW-1:0]   pick;
   logic            pick_vld;
   logic            take;
   logic            noop;
   logic [GW-1:0]   ptr_nxt;

   rr_arbiter #(.NREQ(NREQ)) u_rr (
      .req   (req),
      .ptr   (rr_ptr),
      .grant (pick),
      .valid (pick_vld)
   );

   // Grant qualification and no-op detection for the requester being picked
   always_comb begin
      take = (state == IDLE) && pick_vld;
      noop = (src[pick] == dst[pick]);
   end

   // Pointer advance past the requester just served, modulo NREQ
   always_comb begin
      ptr_nxt = (grant_q == GW'(NREQ - 1)) ? '0 : grant_q + GW'(1);
   end

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next-state logic and output decode from registered state
   always_comb begin
      state_nxt = state;
      reg_oe    = '0;
      reg_ce    = '0;
      ack       = '0;
      busy      = 1'b1;
      case (state)
         IDLE: begin
            busy = 1'b0;
            if (take) state_nxt = noop ? DONE : DRIVE;
         end
         DRIVE: begin
            reg_oe    = NREG'(1) << src_q;
            state_nxt = LOAD;
         end
         LOAD: begin
            reg_oe    = NREG'(1) << src_q;
            reg_ce    = NREG'(1) << dst_q;
            state_nxt = DONE;
         end
         DONE: begin
            ack       = NREQ'(1) << grant_q;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Latch the winner's indices at grant; move rr_ptr when leaving DONE
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rr_ptr  <= '0;
         grant_q <= '0;
         src_q   <= '0;
         dst_q   <= '0;
      end else begin
         if (take) begin
            grant_q <= pick;
            src_q   <= src[pick];
            dst_q   <= dst[pick];
         end
         if (state == DONE) rr_ptr <= ptr_nxt;
      end
   end

   assign grant_id = grant_q;

endmodule

// File: doc/xfer_arbiter.md
XFER_ARBITER -- requirements
Module: xfer_arbiter

Interface
REQ-001 Parameter NREQ, default 4: number of transfer requesters.
REQ-002 Parameter NREG, default 8: number of bus-attached registers, a power of two; IW = $clog2(NREG).
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst  input  1  reset; asynchronous, active-high.
REQ-005 req  input  NREQ  per-requester transfer request level; held high until ack.
REQ-006 src  input  NREQ x IW  per-requester source register index.
REQ-007 dst  input  NREQ x IW  per-requester destination register index.
REQ-008 ack  output  NREQ  one-hot, one-cycle completion pulse to the granted requester.
REQ-009 reg_oe  output  NREG  one-hot source output-enable onto the shared internal bus.
REQ-010 reg_ce  output  NREG  one-hot destination clock enable, wired to the register ce pins.
REQ-011 busy  output  1  high in any state other than IDLE.
REQ-012 grant_id  output  $clog2(NREQ)  index of the current or last granted requester.

Function
REQ-013 The FSM SHALL have exactly four states: IDLE, DRIVE, LOAD, DONE.
REQ-014 In IDLE with any req high, the block SHALL select one requester by round-robin at the clock edge, starting from rr_ptr.
- Latch src, dst and grant_id.
- Go to DRIVE, or to DONE when src == dst.
REQ-015 In IDLE with no req high, the block SHALL remain in IDLE with all outputs low.
REQ-016 DRIVE SHALL last one cycle with reg_oe[src_q] = 1 and reg_ce = 0 (bus settle), then go to LOAD.
REQ-017 LOAD SHALL last one cycle with reg_oe[src_q] = 1 and reg_ce[dst_q] = 1, then go to DONE.
REQ-018 DONE SHALL last one cycle with ack[grant_id] = 1, reg_oe = 0 and reg_ce = 0, then go to IDLE.
REQ-019 On entering IDLE from DONE, rr_ptr SHALL update to (grant_id + 1) mod NREQ.
REQ-020 Latency: a req first sampled in IDLE at edge N SHALL give DRIVE in cycle N+1, LOAD in N+2 and ack in N+3 (src == dst: ack in N+1).
REQ-021 When src == dst, the transfer SHALL complete with ack and SHALL assert no reg_oe or reg_ce.
REQ-022 After a grant, the block SHALL ignore req, src and dst changes until IDLE; a requester dropping req early SHALL still receive ack.
REQ-023 A request still high in the cycle after its ack SHALL be re-arbitrated normally, with lowest priority under the updated rr_ptr.
REQ-024 At most one bit of each of reg_oe, reg_ce and ack SHALL be high in any cycle.
REQ-025 reg_ce SHALL never be high in a cycle where reg_oe is low.
REQ-026 Back-to-back transfers SHALL pass through IDLE for one cycle: 4 cycles per transfer minimum.

Reset
REQ-027 When rst is high, the block SHALL immediately force:
- state = IDLE, rr_ptr = 0, grant_id = 0;
- src_q = dst_q = 0;
- ack, reg_oe, reg_ce, busy = 0.
REQ-028 Reset asserted mid-transfer SHALL abort the transfer with no ack, and all strobes SHALL drop asynchronously.
REQ-029 After rst deasserts, arbitration SHALL resume on the first rising edge.

Structure
REQ-030 Package xfer_pkg SHALL hold:
- the state enum (IDLE, DRIVE, LOAD, DONE);
- the default NREQ and NREG constants.
REQ-031 The round-robin priority pick SHALL be a sub-module rr_arbiter.
- Combinational.
- Inputs: req vector, rr_ptr.
- Outputs: grant index, valid.
REQ-032 All outputs SHALL be decoded from registered state and latched indices only, with no combinational path from req, src or dst.

Verification
REQ-033 Single request: req[2] = 1, src[2] = 3, dst[2] = 5 -> reg_oe = 8'h08 for 2 cycles, reg_ce = 8'h20 in the second, ack = 4'b0100 in the third.
REQ-034 Fairness: req = 4'b1111 held, re-asserted after each ack -> grants in order 0, 1, 2, 3, 0; each ack 4 cycles apart.
REQ-035 No-op: req[1] = 1, src = dst = 6 -> ack[1] one cycle after grant; reg_oe and reg_ce never high.
REQ-036 Early drop: req[0] high one cycle only, src = 1, dst = 2 -> full DRIVE/LOAD/DONE sequence, ack[0] pulses.
REQ-037 Reset mid-LOAD: assert rst during LOAD -> reg_ce and reg_oe low immediately, no ack; the next request is granted from rr_ptr = 0.
REQ-038 Assertions on all runs: one-hot-or-zero for ack, reg_oe, reg_ce; reg_ce implies reg_oe; busy == (state != IDLE).
